// File: rtl/pixel_shifter_pkg.sv
// Shared types and constants for the pixel shifter.
// Widths, border index and the mode-flag priority helper.
package pixel_shifter_pkg;

  localparam int SR_WIDTH  = 8;
  localparam int PEN_WIDTH = 4;
  localparam int CNT_WIDTH = 4;
  localparam int IDX_WIDTH = 5;

  localparam logic [CNT_WIDTH-1:0] SHIFT_MAX = 4'd8;
  localparam logic [IDX_WIDTH-1:0] BORDER_IDX = 5'h10;

  typedef logic [SR_WIDTH-1:0]  sr_t;
  typedef logic [PEN_WIDTH-1:0] pen_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef logic [IDX_WIDTH-1:0] idx_t;

  typedef enum logic [1:0] {
    MODE_1 = 2'd0,
    MODE_0 = 2'd1,
    MODE_2 = 2'd2
  } mode_e;

  // Mode 2 wins when both flags are set; neither set means mode 1.
  function automatic mode_e mode_sel(
    input logic m0,
    input logic m2
  );
    if (m2) return MODE_2;
    if (m0) return MODE_0;
    return MODE_1;
  endfunction

endpackage

// File: rtl/pixel_shifter_if.sv
// Control/data bundle between the video sequencer and the shifter.
// master drives VD/strobes/modes; slave returns index, pen and flags.
interface pixel_shifter_if;
  import pixel_shifter_pkg::*;

  sr_t  VD;
  logic LOAD;
  logic SHIFT;
  logic KEEP;
  logic COLOUR_KEEP;
  logic INK_SEL;
  logic BORDER_SEL;
  logic MODE_IS_0;
  logic MODE_IS_2;
  idx_t COLOUR_IDX;
  pen_t PEN;
  logic OVERSHIFT;
  logic SR_EMPTY;

  modport master (
    output VD,
    output LOAD,
    output SHIFT,
    output KEEP,
    output COLOUR_KEEP,
    output INK_SEL,
    output BORDER_SEL,
    output MODE_IS_0,
    output MODE_IS_2,
    input  COLOUR_IDX,
    input  PEN,
    input  OVERSHIFT,
    input  SR_EMPTY
  );

  modport slave (
    input  VD,
    input  LOAD,
    input  SHIFT,
    input  KEEP,
    input  COLOUR_KEEP,
    input  INK_SEL,
    input  BORDER_SEL,
    input  MODE_IS_0,
    input  MODE_IS_2,
    output COLOUR_IDX,
    output PEN,
    output OVERSHIFT,
    output SR_EMPTY
  );

endinterface

// File: rtl/pixel_shifter_pen_decode.sv
// Combinational pen decode from the shift register and mode flags.
// Ports: sr_i, mode0_i, mode2_i in; pen_o out.
module pixel_pen_decode
  import pixel_shifter_pkg::*;
(
  input  sr_t  sr_i,
  input  logic mode0_i,
  input  logic mode2_i,
  output pen_t pen_o
);

  mode_e mode;

  assign mode = mode_sel(mode0_i, mode2_i);

  // Higher-colour modes take their extra pen bits from
  // the interleaved positions of the video byte.
  always_comb begin
    pen_o = '0;
    unique case (mode)
      MODE_2: pen_o = {3'b000, sr_i[7]};
      MODE_1: pen_o = {2'b00, sr_i[3], sr_i[7]};
      MODE_0: pen_o = {sr_i[1], sr_i[5],
                       sr_i[3], sr_i[7]};
      default: pen_o = '0;
    endcase
  end

endmodule

// File: rtl/pixel_shifter.sv
// Video byte shift register, pen register and palette index output.
// Ports: CLK_n, RESET_n plain; everything else on the slave bus.
module pixel_shifter
  import pixel_shifter_pkg::*;
(
  input  logic           CLK_n,
  input  logic           RESET_n,
  pixel_shifter_if.slave bus
);

  sr_t  sr_q, sr_d;
  cnt_t cnt_q, cnt_d;
  pen_t pen_q, pen_d;
  pen_t pen_dec;
  idx_t idx_q, idx_d;
  logic empty;

  pixel_pen_decode u_dec (
    .sr_i    (sr_q),
    .mode0_i (bus.MODE_IS_0),
    .mode2_i (bus.MODE_IS_2),
    .pen_o   (pen_dec)
  );

  assign empty = (cnt_q == SHIFT_MAX);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (bus.LOAD) begin
      sr_d  = bus.VD;
      cnt_d = '0;
    end else if (bus.SHIFT) begin
      sr_d = {sr_q[SR_WIDTH-2:0], 1'b0};
      if (cnt_q < SHIFT_MAX)
        cnt_d = cnt_q + 1'b1;
    end else if (bus.KEEP) begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    pen_d = bus.COLOUR_KEEP ? pen_q : pen_dec;
  end

  always_comb begin
    idx_d = idx_q;
    if (bus.BORDER_SEL)
      idx_d = BORDER_IDX;
    else if (bus.INK_SEL)
      idx_d = {1'b0, pen_q};
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      sr_q  <= '0;
      cnt_q <= SHIFT_MAX;
      pen_q <= '0;
      idx_q <= BORDER_IDX;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      pen_q <= pen_d;
      idx_q <= idx_d;
    end
  end

  assign bus.PEN        = pen_q;
  assign bus.COLOUR_IDX = idx_q;
  assign bus.SR_EMPTY   = empty;
  // Flags the cycle in which a shift is requested
  // with nothing left; forced low while in reset.
  assign bus.OVERSHIFT  = RESET_n & bus.SHIFT &
                          ~bus.LOAD & empty;

endmodule

// File: tb/tb_pixel_shifter.sv
// Directed table-driven bench for pixel_shifter.
// Covers decode modes, latency, overshift and async reset.
module tb_pixel_shifter;
  import pixel_shifter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pixel_shifter_if bus ();

  pixel_shifter dut (
    .CLK_n   (clk),
    .RESET_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic       ld, sh, kp, ck;
    logic       ink, bor, m0, m2;
    logic [7:0] vd;
    logic       ovs;
    logic [3:0] pen;
    logic [4:0] idx;
    logic       emp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ld, sh, kp, ck,
    input logic ink, bor, m0, m2,
    input logic [7:0] vd,
    input logic ovs,
    input logic [3:0] pen,
    input logic [4:0] idx,
    input logic emp
  );
    vec_t v;
    v.ld = ld; v.sh = sh; v.kp = kp; v.ck = ck;
    v.ink = ink; v.bor = bor; v.m0 = m0; v.m2 = m2;
    v.vd = vd; v.ovs = ovs; v.pen = pen;
    v.idx = idx; v.emp = emp;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.LOAD        = v.ld;
    bus.SHIFT       = v.sh;
    bus.KEEP        = v.kp;
    bus.COLOUR_KEEP = v.ck;
    bus.INK_SEL     = v.ink;
    bus.BORDER_SEL  = v.bor;
    bus.MODE_IS_0   = v.m0;
    bus.MODE_IS_2   = v.m2;
    bus.VD          = v.vd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pen"}, 32'(bus.PEN), 32'h0);
    chk({tag, " idx"}, 32'(bus.COLOUR_IDX), 32'h10);
    chk({tag, " emp"}, 32'(bus.SR_EMPTY), 32'h1);
    chk({tag, " ovs"}, 32'(bus.OVERSHIFT), 32'h0);
  endtask

  initial begin
    //      ld sh kp ck in bo m0 m2  vd     ov pen idx    em
    // mode 2, A5, load + 7 shifts, ink on
    tbl.push_back(mk(1,0,0,0,1,0,0,1,8'hA5,0,4'h0,5'h00,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,1,8'h00,0,4'h1,5'h00,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,1,8'h00,0,4'h0,5'h01,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,1,8'h00,0,4'h1,5'h00,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,1,8'h00,0,4'h0,5'h01,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,1,8'h00,0,4'h0,5'h00,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,1,8'h00,0,4'h1,5'h00,0));
    tbl.push_back(mk(0,1,0,0,1,0,0,1,8'h00,0,4'h0,5'h01,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,1,8'h00,0,4'h1,5'h00,0));
    tbl.push_back(mk(0,0,1,0,1,0,0,1,8'h00,0,4'h1,5'h01,0));
    // mode 0, AA
    tbl.push_back(mk(1,0,0,0,1,0,1,0,8'hAA,0,4'h1,5'h01,0));
    tbl.push_back(mk(0,1,0,0,1,0,1,0,8'h00,0,4'hF,5'h01,0));
    tbl.push_back(mk(0,1,0,0,1,0,1,0,8'h00,0,4'h0,5'h0F,0));
    // mode 1, 88, colour keep on second update
    tbl.push_back(mk(1,0,0,0,0,0,0,0,8'h88,0,4'h3,5'h0F,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,8'h00,0,4'h3,5'h0F,0));
    tbl.push_back(mk(0,1,0,1,0,0,0,0,8'h00,0,4'h3,5'h0F,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,8'h00,0,4'h0,5'h0F,0));
    // border beats ink
    tbl.push_back(mk(0,0,0,0,1,1,0,0,8'h00,0,4'h0,5'h10,0));
    // both mode flags -> mode 2
    tbl.push_back(mk(1,0,0,0,0,0,1,1,8'hAA,0,4'h0,5'h10,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,1,8'h00,0,4'h1,5'h10,0));
    // load+shift 81, then nine shifts in mode 0
    tbl.push_back(mk(1,1,0,0,0,0,1,0,8'h81,0,4'hF,5'h10,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,8'h00,0,4'h1,5'h10,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,0,8'h00,0,4'h1,5'h10,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,0,8'h00,0,4'h8,5'h10,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,0,8'h00,0,4'h0,5'h10,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,0,8'h00,0,4'h2,5'h10,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,0,8'h00,0,4'h0,5'h10,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,0,8'h00,0,4'h4,5'h10,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,0,8'h00,0,4'h0,5'h10,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,0,8'h00,0,4'h1,5'h10,1));
    tbl.push_back(mk(0,1,0,0,0,0,1,0,8'h00,1,4'h0,5'h10,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,8'h00,0,4'h0,5'h10,1));

    // reset state
    drive(mk(0,0,0,0,0,0,0,0,8'h00,0,4'h0,5'h00,0));
    repeat (2) tick();
    chk_reset("rst");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d ovs", i),
          32'(bus.OVERSHIFT), 32'(tbl[i].ovs));
      tick();
      chk($sformatf("v%0d pen", i),
          32'(bus.PEN), 32'(tbl[i].pen));
      chk($sformatf("v%0d idx", i),
          32'(bus.COLOUR_IDX), 32'(tbl[i].idx));
      chk($sformatf("v%0d emp", i),
          32'(bus.SR_EMPTY), 32'(tbl[i].emp));
    end

    // mid-byte reset discards the byte asynchronously
    drive(mk(1,0,0,0,1,0,1,0,8'hFF,0,4'h0,5'h00,0));
    tick();
    drive(mk(0,1,0,0,1,0,1,0,8'h00,0,4'h0,5'h00,0));
    tick();
    chk("mid pen", 32'(bus.PEN), 32'hF);
    chk("mid emp", 32'(bus.SR_EMPTY), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    tick();
    chk_reset("held");

    // first edge after release acts immediately
    #2;
    rst_n = 1'b1;
    drive(mk(1,0,0,0,1,0,1,0,8'h22,0,4'h0,5'h00,0));
    tick();
    chk("rel emp", 32'(bus.SR_EMPTY), 32'h0);
    chk("rel pen", 32'(bus.PEN), 32'h0);
    drive(mk(0,0,0,0,1,0,1,0,8'h00,0,4'h0,5'h00,0));
    tick();
    chk("rel pen2", 32'(bus.PEN), 32'hC);
    chk("rel idx", 32'(bus.COLOUR_IDX), 32'h0);
    tick();
    chk("rel idx2", 32'(bus.COLOUR_IDX), 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_shifter.md
PIXEL_SHIFTER -- requirements
Module: pixel_shifter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; the port list is REQ-002 to REQ-015.
REQ-002 CLK_n  in  1  pixel clock; all state updates on its rising edge.
REQ-003 RESET_n  in  1  asynchronous active-low reset.
REQ-004 VD  in  8  video data byte from RAM.
REQ-005 LOAD  in  1  load VD into the shift register.
REQ-006 SHIFT  in  1  shift the register left by one bit.
REQ-007 KEEP  in  1  hold the shift register.
REQ-008 COLOUR_KEEP  in  1  hold the pen register.
REQ-009 INK_SEL  in  1  drive the decoded pen to the output.
REQ-010 BORDER_SEL  in  1  drive the border index to the output.
REQ-011 MODE_IS_0, MODE_IS_2  in  1 each  synced mode flags; both low = mode 1.
REQ-012 COLOUR_IDX  out  5  palette index; 0-15 = pen, 5'h10 = border.
REQ-013 PEN  out  4  current decoded pen register.
REQ-014 OVERSHIFT  out  1  one-cycle pulse: SHIFT with no valid bits left.
REQ-015 SR_EMPTY  out  1  high when 8 shifts have occurred since the last LOAD.

Function
REQ-016 The shift register (SR, 8 bits) SHALL update each edge with priority LOAD > SHIFT > hold: LOAD gives SR<=VD; SHIFT gives SR<={SR[6:0],0}; otherwise (KEEP or no control) SR holds.
REQ-017 The shift counter (4 bits) SHALL clear to 0 on LOAD, increment on SHIFT while below 8, and saturate at 8; SR_EMPTY = (count==8).
REQ-018 SHIFT with count==8 and no LOAD SHALL assert OVERSHIFT for that one cycle; SR shifts zeros as normal.
REQ-019 Pen decode from SR: mode 2 -> {000,SR[7]}; mode 1 -> {00,SR[3],SR[7]}; mode 0 -> {SR[1],SR[5],SR[3],SR[7]}.
REQ-020 If both MODE_IS_0 and MODE_IS_2 are high, decode SHALL use mode 2.
REQ-021 PEN SHALL register the decode of the current SR at each edge when COLOUR_KEEP=0, and hold when COLOUR_KEEP=1.
REQ-022 COLOUR_IDX SHALL register at each edge: BORDER_SEL=1 gives 5'h10 (border wins if INK_SEL is also high); else INK_SEL=1 gives {0,PEN}; else hold.
REQ-023 Latency: VD captured at edge N (LOAD) SHALL appear in PEN at edge N+1 and in COLOUR_IDX at edge N+2, provided COLOUR_KEEP=0 at N+1 and INK_SEL=1 at N+2.
REQ-024 Mode flags SHALL be sampled combinationally at each PEN update; a mode change mid-byte affects only subsequent pen updates.
REQ-025 PEN and COLOUR_IDX SHALL NOT be gated by SR_EMPTY; an empty SR decodes as pen 0.

Reset
REQ-026 While RESET_n=0: SR=8'h00, count=8 (SR_EMPTY=1), PEN=0, COLOUR_IDX=5'h10, OVERSHIFT=0.
REQ-027 Reset asserted mid-byte SHALL discard the byte immediately.
REQ-028 After RESET_n rises, the first edge SHALL obey REQ-016 to REQ-022 with no extra idle cycle.

Structure
REQ-029 A shared package SHALL define BORDER_IDX=5'h10, SR_WIDTH=8, PEN_WIDTH=4 and SHIFT_MAX=8.
REQ-030 Pen decode SHALL be one combinational sub-module, pixel_pen_decode (SR and mode flags in, 4-bit pen out); all state lives in pixel_shifter.

Verification
REQ-031 Mode 2, VD=8'hA5, LOAD then 7 SHIFTs, COLOUR_KEEP=0, INK_SEL=1 -> COLOUR_IDX from edge N+2 is 1,0,1,0,0,1,0,1.
REQ-032 Mode 0, VD=8'hAA, LOAD then SHIFT -> PEN = 4'hF, then 4'h0.
REQ-033 Mode 1, VD=8'h88, LOAD then 3 SHIFTs -> PEN = 3,0,0,0; COLOUR_KEEP=1 on the second update -> PEN stays 3 for that cycle.
REQ-034 LOAD and SHIFT together with VD=8'h81 -> SR=8'h81 and count=0; nine SHIFTs after a LOAD -> OVERSHIFT high on the ninth only, SR_EMPTY high from the eighth.
REQ-035 BORDER_SEL and INK_SEL both high -> COLOUR_IDX=5'h10; RESET_n low mid-byte -> all outputs take REQ-026 values asynchronously, before the next clock edge.
